// File: rtl/sd_spi_init_seq.sv
// SPI-mode SD card initialisation sequencer: dummy clocks, CMD0/CMD8/CMD55+ACMD41/CMD58,
// hardware CRC7, card classification and slow-to-fast SPI divider switch.
module sd_spi_init_seq #(
  parameter int unsigned      DIV_W        = 2,
  parameter logic [DIV_W-1:0] DIV_INIT     = 2'b11,
  parameter logic [DIV_W-1:0] DIV_FAST     = 2'b00,
  parameter int unsigned      DUMMY_FRAMES = 2,
  parameter int unsigned      CMD0_RETRY   = 8,
  parameter int unsigned      ACMD41_RETRY = 255,
  parameter int unsigned      TIMEOUT_CYC  = 65535
) (
  input  logic             sdinit_clk_i,
  input  logic             sdinit_rst_n_i,
  input  logic             init_start_i,
  input  logic             spi_done_i,
  input  logic [47:0]      spi_data_i,
  output logic             spi_start_o,
  output logic             spi_cs_n_o,
  output logic [47:0]      instruction_sd_o,
  output logic [DIV_W-1:0] clock_divider_o,
  output logic             init_busy_o,
  output logic             init_done_o,
  output logic             init_err_o,
  output logic [2:0]       err_code_o,
  output logic             card_v2_o,
  output logic             sdhc_o,
  output logic [31:0]      ocr_o
);

  localparam int unsigned DUM_W = (DUMMY_FRAMES < 1) ? 1 : $clog2(DUMMY_FRAMES + 1);
  localparam int unsigned C0_W  = (CMD0_RETRY < 1) ? 1 : $clog2(CMD0_RETRY + 1);
  localparam int unsigned A41_W = (ACMD41_RETRY < 1) ? 1 : $clog2(ACMD41_RETRY + 1);
  localparam int unsigned WD_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [47:0] FRAME_IDLE = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_CRC, S_SEND, S_WAIT, S_CHECK, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
  } cmd_e;

  function automatic logic [39:0] cmd_word(input cmd_e c, input logic v2);
    logic [5:0]  idx;
    logic [31:0] arg;
    idx = 6'd0;
    arg = 32'h0;
    case (c)
      C_CMD8:   begin idx = 6'd8;  arg = 32'h0000_01AA; end
      C_CMD55:  idx = 6'd55;
      C_ACMD41: begin idx = 6'd41; arg = v2 ? 32'h4000_0000 : 32'h0; end
      C_CMD58:  idx = 6'd58;
      default:  ;
    endcase
    return {2'b01, idx, arg};
  endfunction

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic               dummy_q, dummy_d;
  logic [DUM_W-1:0]   dum_cnt_q, dum_cnt_d;
  logic [39:0]        cmd_word_q, cmd_word_d;
  logic [39:0]        shift_q, shift_d;
  logic [6:0]         crc_q, crc_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [C0_W-1:0]    c0_cnt_q, c0_cnt_d;
  logic [A41_W-1:0]   a41_cnt_q, a41_cnt_d;
  logic [39:0]        resp_q, resp_d;
  logic               start_q, start_d;
  logic               cs_n_q, cs_n_d;
  logic [47:0]        frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               v2_q, v2_d;
  logic               sdhc_q, sdhc_d;
  logic [31:0]        ocr_q, ocr_d;

  logic        go_cmd, go_done, go_err;
  cmd_e        next_cmd;
  logic [2:0]  err_nx;
  logic [39:0] word_nx;
  logic        crc_fb;
  logic [6:0]  crc_nx;
  logic [7:0]  r1;
  logic [31:0] payload;
  logic        unused_crc_bits;

  // The trailing byte of a response frame carries no information we act on.
  assign unused_crc_bits = ^spi_data_i[7:0];

  // CRC7 generator x^7 + x^3 + 1, command bits shifted in MSB first.
  assign crc_fb  = shift_q[39] ^ crc_q[6];
  assign crc_nx  = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  assign r1      = resp_q[39:32];
  assign payload = resp_q[31:0];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dummy_d    = dummy_q;
    dum_cnt_d  = dum_cnt_q;
    cmd_word_d = cmd_word_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    bit_cnt_d  = bit_cnt_q;
    wd_d       = wd_q;
    c0_cnt_d   = c0_cnt_q;
    a41_cnt_d  = a41_cnt_q;
    resp_d     = resp_q;
    start_d    = 1'b0;
    cs_n_d     = cs_n_q;
    frame_d    = frame_q;
    div_d      = div_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    v2_d       = v2_q;
    sdhc_d     = sdhc_q;
    ocr_d      = ocr_q;
    go_cmd     = 1'b0;
    go_done    = 1'b0;
    go_err     = 1'b0;
    next_cmd   = cmd_q;
    err_nx     = 3'd0;
    word_nx    = 40'h0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (init_start_i) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = 3'd0;
          v2_d       = 1'b0;
          sdhc_d     = 1'b0;
          ocr_d      = 32'h0;
          div_d      = DIV_INIT;
          busy_d     = 1'b1;
          cs_n_d     = 1'b1;
          frame_d    = FRAME_IDLE;
          dummy_d    = 1'b1;
          dum_cnt_d  = '0;
          c0_cnt_d   = '0;
          a41_cnt_d  = '0;
          state_d    = S_DUMMY;
        end
      end
      S_DUMMY: begin
        if (dum_cnt_q == DUM_W'(DUMMY_FRAMES)) begin
          dummy_d  = 1'b0;
          go_cmd   = 1'b1;
          next_cmd = C_CMD0;
        end else begin
          cs_n_d  = 1'b1;
          frame_d = FRAME_IDLE;
          start_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_CRC: begin
        shift_d   = {shift_q[38:0], 1'b0};
        crc_d     = crc_nx;
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'd39) begin
          frame_d = {cmd_word_q, crc_nx, 1'b1};
          cs_n_d  = 1'b0;
          start_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        wd_d    = WD_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done_i) begin
          resp_d = spi_data_i[47:8];
          if (dummy_q) begin
            dum_cnt_d = dum_cnt_q + 1'b1;
            state_d   = S_DUMMY;
          end else begin
            state_d = S_CHECK;
          end
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          go_err = 1'b1;
          err_nx = 3'd5;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_CHECK: begin
        case (cmd_q)
          C_CMD0: begin
            if (r1 == 8'h01) begin
              go_cmd = 1'b1; next_cmd = C_CMD8;
            end else if (c0_cnt_q == C0_W'(CMD0_RETRY - 1)) begin
              go_err = 1'b1; err_nx = 3'd1;
            end else begin
              c0_cnt_d = c0_cnt_q + 1'b1;
              go_cmd = 1'b1; next_cmd = C_CMD0;
            end
          end
          C_CMD8: begin
            if (r1 == 8'h01 && payload[11:0] == 12'h1AA) begin
              v2_d = 1'b1; go_cmd = 1'b1; next_cmd = C_CMD55;
            end else if (r1 == 8'h05) begin
              v2_d = 1'b0; go_cmd = 1'b1; next_cmd = C_CMD55;
            end else begin
              go_err = 1'b1; err_nx = 3'd2;
            end
          end
          C_CMD55: begin
            if (r1 == 8'h00 || r1 == 8'h01) begin
              go_cmd = 1'b1; next_cmd = C_ACMD41;
            end else begin
              go_err = 1'b1; err_nx = 3'd4;
            end
          end
          C_ACMD41: begin
            if (r1 == 8'h00) begin
              if (v2_q) begin
                go_cmd = 1'b1; next_cmd = C_CMD58;
              end else begin
                go_done = 1'b1;
              end
            end else if (r1 == 8'h01) begin
              if (a41_cnt_q == A41_W'(ACMD41_RETRY - 1)) begin
                go_err = 1'b1; err_nx = 3'd3;
              end else begin
                a41_cnt_d = a41_cnt_q + 1'b1;
                go_cmd = 1'b1; next_cmd = C_CMD55;
              end
            end else begin
              go_err = 1'b1; err_nx = 3'd4;
            end
          end
          C_CMD58: begin
            if (r1 == 8'h00) begin
              ocr_d   = payload;
              sdhc_d  = payload[30];
              go_done = 1'b1;
            end else begin
              go_err = 1'b1; err_nx = 3'd4;
            end
          end
          default: begin
            go_err = 1'b1; err_nx = 3'd4;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    if (go_cmd) begin
      word_nx    = cmd_word(next_cmd, v2_d);
      cmd_d      = next_cmd;
      cmd_word_d = word_nx;
      shift_d    = word_nx;
      crc_d      = 7'd0;
      bit_cnt_d  = 6'd0;
      state_d    = S_CRC;
    end
    if (go_done) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cs_n_d  = 1'b1;
      div_d   = DIV_FAST;
      frame_d = FRAME_IDLE;
      state_d = S_DONE;
    end
    if (go_err) begin
      err_d      = 1'b1;
      err_code_d = err_nx;
      busy_d     = 1'b0;
      cs_n_d     = 1'b1;
      frame_d    = FRAME_IDLE;
      state_d    = S_ERR;
    end
  end

  always_ff @(posedge sdinit_clk_i or negedge sdinit_rst_n_i) begin
    if (!sdinit_rst_n_i) begin
      state_q    <= S_IDLE;
      cmd_q      <= C_CMD0;
      dummy_q    <= 1'b0;
      dum_cnt_q  <= '0;
      cmd_word_q <= 40'h0;
      shift_q    <= 40'h0;
      crc_q      <= 7'd0;
      bit_cnt_q  <= 6'd0;
      wd_q       <= '0;
      c0_cnt_q   <= '0;
      a41_cnt_q  <= '0;
      resp_q     <= 40'h0;
      start_q    <= 1'b0;
      cs_n_q     <= 1'b1;
      frame_q    <= FRAME_IDLE;
      div_q      <= DIV_INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      v2_q       <= 1'b0;
      sdhc_q     <= 1'b0;
      ocr_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dummy_q    <= dummy_d;
      dum_cnt_q  <= dum_cnt_d;
      cmd_word_q <= cmd_word_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      bit_cnt_q  <= bit_cnt_d;
      wd_q       <= wd_d;
      c0_cnt_q   <= c0_cnt_d;
      a41_cnt_q  <= a41_cnt_d;
      resp_q     <= resp_d;
      start_q    <= start_d;
      cs_n_q     <= cs_n_d;
      frame_q    <= frame_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      v2_q       <= v2_d;
      sdhc_q     <= sdhc_d;
      ocr_q      <= ocr_d;
    end
  end

  assign spi_start_o      = start_q;
  assign spi_cs_n_o       = cs_n_q;
  assign instruction_sd_o = frame_q;
  assign clock_divider_o  = div_q;
  assign init_busy_o      = busy_q;
  assign init_done_o      = done_q;
  assign init_err_o       = err_q;
  assign err_code_o       = err_code_q;
  assign card_v2_o        = v2_q;
  assign sdhc_o           = sdhc_q;
  assign ocr_o            = ocr_q;

endmodule

// File: tb/tb_sd_spi_init_seq.sv
// Directed bench for sd_spi_init_seq: SDHC, v1, CMD0 failure, ACMD41 exhaustion,
// SPI timeout with recovery, and asynchronous reset during a transfer.
module tb_sd_spi_init_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic        spi_done;
  logic [47:0] spi_data;
  logic        spi_start;
  logic        cs_n;
  logic [47:0] frame;
  logic [1:0]  div;
  logic        busy, done, err, v2, sdhc;
  logic [2:0]  err_code;
  logic [31:0] ocr;

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] ONES   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] F_CMD0 = 48'h4000_0000_0095;
  localparam logic [47:0] F_CMD8 = 48'h4800_0001_AA87;
  localparam logic [47:0] F_C55  = 48'h7700_0000_0065;
  localparam logic [47:0] F_A41H = 48'h6940_0000_0077;
  localparam logic [47:0] F_A41Z = 48'h6900_0000_00E5;
  localparam logic [47:0] F_C58  = 48'h7A00_0000_00FD;
  localparam logic [47:0] R_01   = 48'h01FF_FFFF_FFFF;
  localparam logic [47:0] R_00   = 48'h00FF_FFFF_FFFF;
  localparam logic [47:0] R_05   = 48'h05FF_FFFF_FFFF;
  localparam logic [47:0] R_7    = 48'h0100_0001_AAFF;
  localparam logic [47:0] R_OCR  = 48'h00C0_FF80_00FF;

  always #5 clk = ~clk;

  sd_spi_init_seq #(
    .ACMD41_RETRY(4),
    .TIMEOUT_CYC (100)
  ) dut (
    .sdinit_clk_i    (clk),
    .sdinit_rst_n_i  (rst_n),
    .init_start_i    (init_start),
    .spi_done_i      (spi_done),
    .spi_data_i      (spi_data),
    .spi_start_o     (spi_start),
    .spi_cs_n_o      (cs_n),
    .instruction_sd_o(frame),
    .clock_divider_o (div),
    .init_busy_o     (busy),
    .init_done_o     (done),
    .init_err_o      (err),
    .err_code_o      (err_code),
    .card_v2_o       (v2),
    .sdhc_o          (sdhc),
    .ocr_o           (ocr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
  endtask

  task automatic wait_start(output logic [47:0] fr, output logic cs, output logic ok);
    ok = 1'b0;
    fr = '0;
    cs = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        fr = frame;
        cs = cs_n;
      end
    end
  endtask

  task automatic serve(input string tag, input logic [47:0] exp_fr, input logic exp_cs,
                       input logic [47:0] resp);
    logic [47:0] fr;
    logic        cs, ok;
    wait_start(fr, cs, ok);
    chk({tag, " started"}, 64'(ok), 64'd1);
    chk({tag, " frame"}, 64'(fr), 64'(exp_fr));
    chk({tag, " cs_n"}, 64'(cs), 64'(exp_cs));
    repeat (3) @(negedge clk);
    chk({tag, " frame held"}, 64'(frame), 64'(exp_fr));
    spi_data = resp;
    spi_done = 1'b1;
    @(negedge clk) spi_done = 1'b0;
    $display("xfer %-12s frame=%h cs_n=%b resp=%h", tag, fr, cs, resp);
  endtask

  task automatic count_starts(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) n++;
    end
  endtask

  task automatic dummies();
    serve("dummy0", ONES, 1'b1, ONES);
    serve("dummy1", ONES, 1'b1, ONES);
  endtask

  task automatic run_sdhc(input string tag);
    pulse_start();
    chk({tag, " busy"}, 64'(busy), 64'd1);
    dummies();
    serve("cmd0", F_CMD0, 1'b0, R_01);
    serve("cmd8", F_CMD8, 1'b0, R_7);
    serve("cmd55a", F_C55, 1'b0, R_01);
    serve("acmd41a", F_A41H, 1'b0, R_01);
    serve("cmd55b", F_C55, 1'b0, R_01);
    serve("acmd41b", F_A41H, 1'b0, R_01);
    serve("cmd55c", F_C55, 1'b0, R_01);
    serve("acmd41c", F_A41H, 1'b0, R_00);
    serve("cmd58", F_C58, 1'b0, R_OCR);
    repeat (3) @(negedge clk);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " busy end"}, 64'(busy), 64'd0);
    chk({tag, " card_v2"}, 64'(v2), 64'd1);
    chk({tag, " sdhc"}, 64'(sdhc), 64'd1);
    chk({tag, " ocr"}, 64'(ocr), 64'hC0FF_8000);
    chk({tag, " divider"}, 64'(div), 64'd0);
    chk({tag, " cs_n end"}, 64'(cs_n), 64'd1);
    chk({tag, " frame end"}, 64'(frame), 64'(ONES));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " spi_start"}, 64'(spi_start), 64'd0);
    chk({tag, " cs_n"}, 64'(cs_n), 64'd1);
    chk({tag, " frame"}, 64'(frame), 64'(ONES));
    chk({tag, " divider"}, 64'(div), 64'd3);
    chk({tag, " status"}, 64'({busy, done, err, err_code, v2, sdhc}), 64'd0);
    chk({tag, " ocr"}, 64'(ocr), 64'd0);
  endtask

  initial begin
    int          n;
    logic [47:0] fr;
    logic        cs, ok;

    rst_n      = 1'b0;
    init_start = 1'b0;
    spi_done   = 1'b0;
    spi_data   = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal v2 SDHC card.
    run_sdhc("sdhc");

    // v1 card: CMD8 illegal, ACMD41 with zero argument, no CMD58.
    pulse_start();
    chk("v1 cleared done", 64'(done), 64'd0);
    dummies();
    serve("v1 cmd0", F_CMD0, 1'b0, R_01);
    serve("v1 cmd8", F_CMD8, 1'b0, R_05);
    serve("v1 cmd55", F_C55, 1'b0, R_01);
    serve("v1 acmd41", F_A41Z, 1'b0, R_00);
    count_starts(200, n);
    chk("v1 no cmd58", 64'(n), 64'd0);
    chk("v1 done", 64'(done), 64'd1);
    chk("v1 card_v2", 64'(v2), 64'd0);
    chk("v1 sdhc", 64'(sdhc), 64'd0);
    chk("v1 divider", 64'(div), 64'd0);

    // CMD0 never answered: eight attempts then code 1.
    pulse_start();
    dummies();
    for (int i = 0; i < 8; i++) serve("cmd0 ff", F_CMD0, 1'b0, ONES);
    count_starts(200, n);
    chk("cmd0 no ninth", 64'(n), 64'd0);
    chk("cmd0 err", 64'(err), 64'd1);
    chk("cmd0 code", 64'(err_code), 64'd1);
    chk("cmd0 divider", 64'(div), 64'd3);
    chk("cmd0 done", 64'(done), 64'd0);

    // ACMD41 stuck idle: four pairs then code 3.
    pulse_start();
    dummies();
    serve("a41 cmd0", F_CMD0, 1'b0, R_01);
    serve("a41 cmd8", F_CMD8, 1'b0, R_7);
    for (int i = 0; i < 4; i++) begin
      serve("a41 cmd55", F_C55, 1'b0, R_01);
      serve("a41 acmd41", F_A41H, 1'b0, R_01);
    end
    count_starts(200, n);
    chk("a41 no fifth", 64'(n), 64'd0);
    chk("a41 err", 64'(err), 64'd1);
    chk("a41 code", 64'(err_code), 64'd3);
    chk("a41 divider", 64'(div), 64'd3);

    // spi_done withheld on CMD0: timeout 100 cycles after spi_start_o.
    pulse_start();
    dummies();
    wait_start(fr, cs, ok);
    chk("tmo cmd0 started", 64'(ok), 64'd1);
    n = 0;
    while (err !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    $display("xfer timeout      frame=%h cycles_to_err=%0d", fr, n);
    chk("tmo cycles", 64'(n), 64'd100);
    chk("tmo code", 64'(err_code), 64'd5);
    chk("tmo busy", 64'(busy), 64'd0);
    run_sdhc("recover");

    // Asynchronous reset in the WAIT of CMD8, then a stray spi_done.
    pulse_start();
    dummies();
    serve("rst cmd0", F_CMD0, 1'b0, R_01);
    wait_start(fr, cs, ok);
    chk("rst cmd8 frame", 64'(fr), 64'(F_CMD8));
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async rst");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    spi_data = R_7;
    spi_done = 1'b1;
    @(negedge clk) spi_done = 1'b0;
    count_starts(200, n);
    chk("stray done starts", 64'(n), 64'd0);
    check_reset_vals("after stray");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
